// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and constants for the M-extension sequencer.
//   state_e        FSM states S_IDLE..S_DONE
//   F3_*           FUNC3 op encodings
//   XLEN_DEF       default operand/result width
//   MUL_LATENCY_DEF default cycles spent in S_MUL
package mdu_pkg;
  localparam int XLEN_DEF        = 32;
  localparam int MUL_LATENCY_DEF = 2;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // DIV/REM are the signed divide ops (FUNC3[0]=0).
  function automatic logic f3_div_signed(logic [2:0] f3);
    return ~f3[0];
  endfunction
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: decode/EX <-> M-unit signal bundle.
//   master: drives START, FUNC3, OP1, OP2, FLUSH; reads RESULT, RESULT_VALID, BUSY, STALL
//   slave : the sequencer side (mirror of master)
interface muldiv_sequencer_if #(parameter int XLEN = mdu_pkg::XLEN_DEF);
  logic            START;
  logic [2:0]      FUNC3;
  logic [XLEN-1:0] OP1;
  logic [XLEN-1:0] OP2;
  logic            FLUSH;
  logic [XLEN-1:0] RESULT;
  logic            RESULT_VALID;
  logic            BUSY;
  logic            STALL;

  modport master (output START, FUNC3, OP1, OP2, FLUSH,
                  input  RESULT, RESULT_VALID, BUSY, STALL);
  modport slave  (input  START, FUNC3, OP1, OP2, FLUSH,
                  output RESULT, RESULT_VALID, BUSY, STALL);
endinterface

// File: rtl/muldiv_sequencer_div_iter_core.sv
// div_iter_core: unsigned restoring divider datapath, one quotient bit per step, MSB first.
//   clk, rst          clock, async active-high reset
//   load              capture dividend/divisor, clear partial remainder
//   step              perform one restoring iteration
//   dividend, divisor unsigned magnitudes
//   quotient, remainder results, valid after XLEN steps
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [XLEN:0]   shl, diff;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  always_comb begin
    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    shl   = {rem_q, quo_q[XLEN-1]};
    diff  = shl - {1'b0, dvs_q};
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (step) begin
      // rem < divisor always, so shl < 2*divisor and diff[XLEN] is a clean borrow
      if (!diff[XLEN]) begin
        rem_d = diff[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d = shl[XLEN-1:0];
        quo_d = {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV M-extension unit beside the EX-stage ALU.
//   CLK, RESET  clock, async active-high reset
//   bus (slave) START/FUNC3/OP1/OP2/FLUSH in; RESULT/RESULT_VALID/BUSY/STALL out
// Multiply sits MUL_LATENCY cycles in S_MUL; divide runs XLEN restoring steps
// in S_DIV; divide-by-zero and signed overflow finish straight from S_IDLE.
// Optional MDU_REUSE_EN: caches the last completed normal divide so a
// matching DIV/REM pair finishes in one cycle.
module muldiv_sequencer
  import mdu_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF
) (
  input logic                CLK,
  input logic                RESET,
  muldiv_sequencer_if.slave  bus
);
  localparam int CNT_MAX = (XLEN > MUL_LATENCY) ? XLEN : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      f3_q, f3_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d, result_q, result_d;
  logic            qneg_q, qneg_d, rneg_q, rneg_d, div_run_q, div_run_d;

  // ---- issue-side decode (S_IDLE) ----
  logic            is_div, sgn, is_rem, dz, ovf, a_neg, b_neg;
  logic [XLEN-1:0] mag1, mag2, special_res;
  logic            hit;
  logic [XLEN-1:0] hit_res;

  always_comb begin
    is_div = bus.FUNC3[2];
    sgn    = f3_div_signed(bus.FUNC3);
    is_rem = bus.FUNC3[1];
    dz     = (bus.OP2 == '0);
    ovf    = sgn && (bus.OP1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.OP2 == '1);
    a_neg  = sgn & bus.OP1[XLEN-1];
    b_neg  = sgn & bus.OP2[XLEN-1];
    mag1   = a_neg ? -bus.OP1 : bus.OP1;
    mag2   = b_neg ? -bus.OP2 : bus.OP2;
    // overflow quotient equals OP1 (most negative value), remainder 0
    if (dz) special_res = is_rem ? bus.OP1 : '1;
    else    special_res = is_rem ? '0 : bus.OP1;
  end

  // ---- multiplier: 33x33 signed product, low 2*XLEN bits via sign-extended operands ----
  logic            a_ext, b_ext;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] mul_res;

  always_comb begin
    a_ext   = ((f3_q == 2'b01) || (f3_q == 2'b10)) & op1_q[XLEN-1];
    b_ext   = (f3_q == 2'b01) & op2_q[XLEN-1];
    prod    = {{XLEN{a_ext}}, op1_q} * {{XLEN{b_ext}}, op2_q};
    mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // ---- divider core + sign fix ----
  logic            core_load, core_step;
  logic [XLEN-1:0] core_quo, core_rem, quo_f, rem_f, div_out, res_out;

  div_iter_core #(.XLEN(XLEN)) u_div (
    .clk       (CLK),
    .rst       (RESET),
    .load      (core_load),
    .step      (core_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_comb begin
    quo_f   = qneg_q ? -core_quo : core_quo;
    rem_f   = rneg_q ? -core_rem : core_rem;
    div_out = f3_q[1] ? rem_f : quo_f;
    // divide result is only final in S_DONE, so it bypasses result_q that cycle
    res_out = (state_q == S_DONE && div_run_q) ? div_out : result_q;
  end

`ifdef MDU_REUSE_EN
  logic            c_vld_q, c_sgn_q, cache_we;
  logic [XLEN-1:0] c_op1_q, c_op2_q, c_quo_q, c_rem_q;

  always_comb begin
    hit     = c_vld_q && (c_sgn_q == sgn) && (c_op1_q == bus.OP1) && (c_op2_q == bus.OP2);
    hit_res = is_rem ? c_rem_q : c_quo_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_vld_q <= 1'b0;
      c_sgn_q <= 1'b0;
      c_op1_q <= '0;
      c_op2_q <= '0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else if (cache_we) begin
      c_vld_q <= 1'b1;
      c_sgn_q <= ~f3_q[0];
      c_op1_q <= op1_q;
      c_op2_q <= op2_q;
      c_quo_q <= quo_f;
      c_rem_q <= rem_f;
    end
  end
`else
  always_comb begin
    hit     = 1'b0;
    hit_res = '0;
  end
`endif

  // ---- FSM ----
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    result_d  = result_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    div_run_d = div_run_q;
    core_load = 1'b0;
    core_step = 1'b0;
`ifdef MDU_REUSE_EN
    cache_we  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.START && !bus.FLUSH) begin
          f3_d      = bus.FUNC3[1:0];
          op1_d     = bus.OP1;
          op2_d     = bus.OP2;
          div_run_d = 1'b0;
          if (!is_div) begin
            state_d = S_MUL;
            cnt_d   = CNT_W'(MUL_LATENCY - 1);
          end else if (dz || ovf) begin
            state_d  = S_DONE;
            result_d = special_res;
          end else if (hit) begin
            state_d  = S_DONE;
            result_d = hit_res;
          end else begin
            state_d   = S_DIV;
            cnt_d     = CNT_W'(XLEN - 1);
            core_load = 1'b1;
            qneg_d    = a_neg ^ b_neg;
            rneg_d    = a_neg;
            div_run_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (bus.FLUSH) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d  = S_DONE;
          result_d = mul_res;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV: begin
        if (bus.FLUSH) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          div_run_d = 1'b0;
        end else begin
          core_step = 1'b1;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        result_d = res_out;
`ifdef MDU_REUSE_EN
        cache_we = div_run_q;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      result_q  <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      div_run_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      result_q  <= result_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      div_run_q <= div_run_d;
    end
  end

  assign bus.RESULT       = res_out;
  assign bus.RESULT_VALID = (state_q == S_DONE);
  assign bus.BUSY         = (state_q != S_IDLE);
  assign bus.STALL        = ((state_q == S_IDLE) && bus.START && !bus.FLUSH) ||
                            (state_q == S_MUL) || (state_q == S_DIV);
endmodule

// File: tb/tb_muldiv_sequencer.sv
`timescale 1ns/1ps
module tb_muldiv_sequencer;
  import mdu_pkg::*;

`ifdef MDU_REUSE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 33;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  muldiv_sequencer_if #(.XLEN(32)) bus ();
  muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // scoreboard: expected result + strobe cycle per issued op
  logic [31:0] exp_res[$];
  int          exp_at[$];
  string       exp_name[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // monitor: every strobe must match the oldest pending expectation
  always @(negedge CLK) begin
    if (bus.RESULT_VALID) begin
      if (exp_res.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: strobe at cycle %0d, result %h, nothing pending", cyc, bus.RESULT);
      end else begin
        logic [31:0] r;
        int a;
        string n;
        r = exp_res.pop_front();
        a = exp_at.pop_front();
        n = exp_name.pop_front();
        chk({n, " result"}, bus.RESULT, r);
        chk({n, " cycle"}, 32'(cyc), 32'(a));
      end
    end
  end

  task automatic issue(input string nm, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int t;
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNC3 = f3; bus.OP1 = a; bus.OP2 = b;
    t = cyc;
    exp_res.push_back(exp); exp_at.push_back(t + lat); exp_name.push_back(nm);
    #1 chk({nm, " stall_t"}, 32'(bus.STALL), 32'd1);
    @(negedge CLK);
    bus.START = 1'b0;
    for (int k = 1; k < lat; k++) begin
      #1 chk({nm, " stall_run"}, 32'(bus.STALL), 32'd1);
      @(negedge CLK);
    end
    #1 chk({nm, " stall_done"}, 32'(bus.STALL), 32'd0);
    for (int i = 0; i < 50 && exp_res.size() != 0; i++) @(negedge CLK);
    if (exp_res.size() != 0) begin
      total++; bad++;
      $display("FAIL %s timeout: no strobe, %0d pending", nm, exp_res.size());
      exp_res.delete(); exp_at.delete(); exp_name.delete();
    end
  endtask

  task automatic start_only(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                            output int t);
    @(negedge CLK);
    bus.START = 1'b1; bus.FUNC3 = f3; bus.OP1 = a; bus.OP2 = b;
    t = cyc;
    @(negedge CLK);
    bus.START = 1'b0;
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, " result"}, bus.RESULT, 32'h0);
    chk({nm, " valid"}, 32'(bus.RESULT_VALID), 32'd0);
    chk({nm, " busy"}, 32'(bus.BUSY), 32'd0);
    chk({nm, " stall"}, 32'(bus.STALL), 32'd0);
  endtask

  initial begin
    int t;
    bus.START = 1'b0; bus.FUNC3 = '0; bus.OP1 = '0; bus.OP2 = '0; bus.FLUSH = 1'b0;
    repeat (3) @(negedge CLK);
    #1 check_idle_outputs("reset");
    RESET = 1'b0;

    issue("mul_7x-3",  F3_MUL,    32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 3);
    issue("mulhu_m1",  F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    issue("mulh_m1",   F3_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 3);
    issue("mulhsu_m1", F3_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);

    issue("div_-7_2",  F3_DIV,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33);
    issue("rem_-7_2",  F3_REM,  32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, HIT_LAT);
    issue("div_7_-2",  F3_DIV,  32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    issue("rem_7_-2",  F3_REM,  32'h7,         32'hFFFF_FFFE, 32'h0000_0001, HIT_LAT);
    issue("divu_big",  F3_DIVU, 32'hFFFF_FFFF, 32'h3,         32'h5555_5555, 33);
    issue("remu_2p31", F3_REMU, 32'h8000_0000, 32'h7,         32'h0000_0002, 33);
    issue("divu_nov",  F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);

    issue("divu_5_0",  F3_DIVU, 32'h5,         32'h0,         32'hFFFF_FFFF, 1);
    issue("rem_5_0",   F3_REM,  32'h5,         32'h0,         32'h0000_0005, 1);
    issue("div_ovf",   F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    issue("rem_ovf",   F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

    // flush at t+10 of a divide: idle at t+11, no strobe, nothing cached
    start_only(F3_DIV, 32'd100, 32'd7, t);
    while (cyc < t + 10) @(negedge CLK);
    bus.FLUSH = 1'b1;
    @(negedge CLK);
    bus.FLUSH = 1'b0;
    #1 chk("flush busy", 32'(bus.BUSY), 32'd0);
    chk("flush stall", 32'(bus.STALL), 32'd0);
    chk("flush cycle", 32'(cyc), 32'(t + 11));
    repeat (40) @(negedge CLK);

    issue("div_100_7",  F3_DIV,  32'd100, 32'd7, 32'd14, 33);
    issue("rem_100_7",  F3_REM,  32'd100, 32'd7, 32'd2,  HIT_LAT);
    issue("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // START together with FLUSH: nothing latched
    @(negedge CLK);
    bus.START = 1'b1; bus.FLUSH = 1'b1; bus.FUNC3 = F3_MUL; bus.OP1 = 32'd3; bus.OP2 = 32'd4;
    #1 chk("startflush stall", 32'(bus.STALL), 32'd0);
    @(negedge CLK);
    bus.START = 1'b0; bus.FLUSH = 1'b0;
    #1 chk("startflush busy", 32'(bus.BUSY), 32'd0);
    repeat (5) @(negedge CLK);

    // reset mid-divide: outputs drop immediately, cache cleared
    start_only(F3_DIVU, 32'd1000, 32'd3, t);
    while (cyc < t + 5) @(negedge CLK);
    RESET = 1'b1;
    #1 check_idle_outputs("midreset");
    @(negedge CLK);
    RESET = 1'b0;
    repeat (40) @(negedge CLK);

    issue("rem_100_7_post", F3_REM, 32'd100, 32'd7, 32'd2, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
